// File: rtl/tdm_demux_1x16_if.sv
// tdm_demux_1x16_if: serial-in / frame-out bus of the 1x16 TDM demultiplexer.
//   in_data, in_valid, frame_start : serial sample stream into the demux
//   out, out_valid                 : latched frame and its 1-cycle update strobe
//   s                              : slot the next accepted sample lands in
//   sync_err, par_err              : 1-cycle error strobes
// master = link side (drives samples), slave = demux side.
interface tdm_demux_1x16_if #(
    parameter int N_OUT  = 16,
    parameter int SEL_W  = 4,
    parameter int DATA_W = 1
);
    logic [DATA_W-1:0]       in_data;
    logic                    in_valid;
    logic                    frame_start;
    logic [N_OUT*DATA_W-1:0] out;
    logic                    out_valid;
    logic [SEL_W-1:0]        s;
    logic                    sync_err;
    logic                    par_err;

    modport master (
        output in_data, in_valid, frame_start,
        input  out, out_valid, s, sync_err, par_err
    );
    modport slave (
        input  in_data, in_valid, frame_start,
        output out, out_valid, s, sync_err, par_err
    );
endinterface

// File: rtl/tdm_demux_1x16.sv
// tdm_demux_1x16: registered 1-to-16 time-division demultiplexer.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : tdm_demux_1x16_if.slave (samples in, frame/strobes out)
// A slot counter steers each accepted sample into a per-slot shadow lane;
// the whole frame moves to bus.out only when the last slot is accepted, so
// out never shows a partially filled frame.
// Optional build macro DEMUX_PARITY_EN: adds slot N_OUT carrying even parity
// over all data bits (bit 0 of that sample); a mismatch drops the frame and
// pulses par_err. Without it par_err is tied low.

// One shadow slot of the frame being collected.
module tdm_demux_lane #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)        q <= '0;
        else if (wr_en) q <= din;
    end
endmodule

module tdm_demux_1x16 #(
    parameter int N_OUT  = 16,
    parameter int SEL_W  = 4,
    parameter int DATA_W = 1
) (
    input  logic               clk,
    input  logic               rst,
    tdm_demux_1x16_if.slave    bus
);
`ifdef DEMUX_PARITY_EN
    // one extra slot for the parity sample
    localparam int CNT_W = SEL_W + 1;
    localparam int LAST  = N_OUT;
`else
    localparam int CNT_W = SEL_W;
    localparam int LAST  = N_OUT - 1;
`endif

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]                   state;
    logic [CNT_W-1:0]             cnt;
    logic [N_OUT-1:0][DATA_W-1:0] shadow;
    logic [N_OUT*DATA_W-1:0]      out_r;
    logic                         out_valid_r, sync_err_r, par_err_r;

    logic             take;     // sample accepted this edge
    logic             restart;  // frame_start mid-frame: resync to slot 0
    logic [CNT_W-1:0] wr_slot;

    always_comb begin
        take    = 1'b0;
        restart = 1'b0;
        wr_slot = cnt;
        if (state == IDLE) begin
            take    = bus.in_valid & bus.frame_start;
            wr_slot = '0;
        end else begin
            take = bus.in_valid;
            // frame_start on slot 0 is just a normal slot-0 sample
            if (bus.frame_start && cnt != '0) begin
                restart = 1'b1;
                wr_slot = '0;
            end
        end
    end

    // The parity slot (index N_OUT) matches no lane, so it is never stored.
    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        tdm_demux_lane #(.DATA_W(DATA_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr_en (take && (wr_slot == CNT_W'(k))),
            .din   (bus.in_data),
            .q     (shadow[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            out_r       <= '0;
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            par_err_r   <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            par_err_r   <= 1'b0;
            if (take) begin
                if (state == IDLE || restart) begin
                    state      <= FILL;
                    cnt        <= CNT_W'(1);
                    sync_err_r <= restart;
                end else if (cnt == CNT_W'(LAST)) begin
                    cnt <= '0;
`ifdef DEMUX_PARITY_EN
                    if (bus.in_data[0] == ^shadow) begin
                        out_r       <= shadow;
                        out_valid_r <= 1'b1;
                    end else begin
                        par_err_r <= 1'b1;
                    end
`else
                    // last sample bypasses its lane straight into out
                    out_r       <= {bus.in_data, shadow[N_OUT-2:0]};
                    out_valid_r <= 1'b1;
`endif
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.s         = cnt[SEL_W-1:0];
    assign bus.sync_err  = sync_err_r;
`ifdef DEMUX_PARITY_EN
    assign bus.par_err   = par_err_r;
`else
    assign bus.par_err   = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux_1x16.sv
// tb_tdm_demux_1x16: scoreboard bench for tdm_demux_1x16. A frame-level model
// (queue of collected samples) runs at stimulus time and pushes expected
// pulses; a monitor pops and compares whenever the DUT strobes.
module tb_tdm_demux_1x16;
    localparam int N = 16;
`ifdef DEMUX_PARITY_EN
    localparam int FLEN = N + 1;
`else
    localparam int FLEN = N;
`endif

    typedef struct packed {
        logic [1:0]  kind;   // 0 frame, 1 sync_err, 2 par_err
        logic [15:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tdm_demux_1x16_if #(.N_OUT(16), .SEL_W(4), .DATA_W(1)) bus ();
    tdm_demux_1x16 #(.N_OUT(16), .SEL_W(4), .DATA_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    ev_t        evq[$];
    logic       m_samp[$];
    bit         m_sync;
    logic [15:0] m_out;
    logic [3:0] m_s;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_samp.delete();
        m_sync = 1'b0;
        m_out  = '0;
        m_s    = '0;
    endfunction

    // Frame-level reference: collect samples, emit a frame when FLEN arrive.
    function automatic void m_step(logic v, logic fs, logic d);
        logic [15:0] f;
        ev_t e;
        if (v) begin
            if (!m_sync) begin
                if (fs) begin
                    m_sync = 1'b1;
                    m_samp.delete();
                    m_samp.push_back(d);
                end
            end else if (fs && m_samp.size() != 0) begin
                e.kind = 2'd1; e.data = '0;
                evq.push_back(e);
                m_samp.delete();
                m_samp.push_back(d);
            end else begin
                m_samp.push_back(d);
                if (m_samp.size() == FLEN) begin
                    for (int k = 0; k < N; k++) f[k] = m_samp[k];
                    if (FLEN == N || ((^f) == m_samp[N])) begin
                        e.kind = 2'd0; e.data = f;
                        m_out = f;
                    end else begin
                        e.kind = 2'd2; e.data = '0;
                    end
                    evq.push_back(e);
                    m_samp.delete();
                end
            end
        end
        m_s = 4'(m_samp.size() % 16);
    endfunction

    task automatic send(logic v, logic fs, logic d);
        @(negedge clk);
        bus.in_valid    = v;
        bus.frame_start = fs;
        bus.in_data     = d;
        m_step(v, fs, d);
    endtask

    task automatic send_word(logic [15:0] w, bit with_fs);
        for (int k = 0; k < N; k++) send(1'b1, (k == 0) && with_fs, w[k]);
`ifdef DEMUX_PARITY_EN
        send(1'b1, 1'b0, ^w);
`endif
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.frame_start = 1'b0; bus.in_data = 1'b0;
        m_reset();
        mon_en = 1'b1;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every strobe against the scoreboard, plus s/out each cycle.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (bus.out_valid || bus.sync_err || bus.par_err) begin
                logic [1:0] gk;
                ev_t e;
                gk = bus.out_valid ? 2'd0 : (bus.sync_err ? 2'd1 : 2'd2);
                if (evq.size() == 0) chk("unexpected_pulse", {30'd0, gk}, 32'hFF);
                else begin
                    e = evq.pop_front();
                    chk("pulse_kind", {30'd0, gk}, {30'd0, e.kind});
                    if (gk == 2'd0) chk("frame_out", {16'd0, bus.out}, {16'd0, e.data});
                end
            end
            chk("valid_and_sync", {31'd0, bus.out_valid & bus.sync_err}, 32'd0);
            chk("slot_s", {28'd0, bus.s}, {28'd0, m_s});
            chk("out_hold", {16'd0, bus.out}, {16'd0, m_out});
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.frame_start = 1'b0; bus.in_data = 1'b0;
        m_reset();

        // reset state
        do_reset(2);
        settle();
        chk("rst_out", {16'd0, bus.out}, 32'h0);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_s", {28'd0, bus.s}, 32'd0);

        // single frame 1,0,0..0
        send_word(16'h0001, 1'b1);
        settle();
        chk("t2_out", {16'd0, bus.out}, 32'h0001);
        chk("t2_s", {28'd0, bus.s}, 32'd0);

        // back-to-back, second frame without frame_start
        send_word(16'h0008, 1'b1);
        send_word(16'h8000, 1'b0);
        settle();
        chk("t3_out", {16'd0, bus.out}, 32'h8000);

        // gap after slot 7
        for (int k = 0; k < 8; k++) send(1'b1, k == 0, 1'((16'hA5A5 >> k) & 1));
        for (int k = 0; k < 5; k++) send(1'b0, 1'b0, 1'b1);
        settle();
        chk("t4_s_hold", {28'd0, bus.s}, 32'd8);
        for (int k = 8; k < 16; k++) send(1'b1, 1'b0, 1'((16'hA5A5 >> k) & 1));
`ifdef DEMUX_PARITY_EN
        send(1'b1, 1'b0, ^16'hA5A5);
`endif
        settle();
        chk("t4_out", {16'd0, bus.out}, 32'hA5A5);

        // frame_start at s=9
        for (int k = 0; k < 9; k++) send(1'b1, k == 0, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        settle();
        chk("t5_sync", {31'd0, bus.sync_err}, 32'd1);
        chk("t5_out_kept", {16'd0, bus.out}, 32'hA5A5);
        chk("t5_s", {28'd0, bus.s}, 32'd1);
        for (int k = 1; k < FLEN; k++) send(1'b1, 1'b0, 1'(k & 1));

        // reset mid-frame at s=12, then in_valid without frame_start ignored
        do_reset(1);
        for (int k = 0; k < 12; k++) send(1'b1, k == 0, 1'b1);
        do_reset(1);
        for (int k = 0; k < 3; k++) send(1'b1, 1'b0, 1'b1);
        settle();
        chk("t6_out", {16'd0, bus.out}, 32'h0);
        chk("t6_s", {28'd0, bus.s}, 32'd0);

`ifdef DEMUX_PARITY_EN
        for (int k = 0; k < N; k++) send(1'b1, k == 0, 1'((16'h0003 >> k) & 1));
        send(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < N; k++) send(1'b1, 1'b0, 1'((16'h0003 >> k) & 1));
        send(1'b1, 1'b0, 1'b0);
        settle();
        chk("t6_par_out", {16'd0, bus.out}, 32'h0003);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1);
            else send($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom));
        end
        send(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", evq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
